// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared framebuffer types and screen geometry
package fb_pkg;

   typedef logic [10:0] coord_t;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam int FB_WIDTH  = 640;
   localparam int FB_HEIGHT = 480;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter, one-hot grant, pointer moves on advance
module rr_arbiter #(
   parameter int N = 2
) (
   input  logic         clk50,
   input  logic         reset_n,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] last_grant;
   logic [PW-1:0] next_grant;
   logic [PW-1:0] idx;
   logic          found;

   // Search begins one past the last winner so every client waits at most N-1 grants.
   always_comb begin
      grant      = '0;
      next_grant = last_grant;
      idx        = '0;
      found      = 1'b0;
      for (int i = 0; i < N; i++) begin
         idx = PW'((int'(last_grant) + 1 + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            next_grant = idx;
            found      = 1'b1;
         end
      end
   end

   // Pointer starts at N-1 so client 0 is searched first after reset.
   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         last_grant <= PW'(N - 1);
      end else if (advance && found) begin
         last_grant <= next_grant;
      end
   end

endmodule

// File: rtl/fb_write_scheduler.sv
// rtl/fb_write_scheduler.sv - shares the framebuffer write port between clients and a clear sequencer
module fb_write_scheduler
   import fb_pkg::*;
#(
   parameter int NREQ   = 2,
   parameter int WIDTH  = FB_WIDTH,
   parameter int HEIGHT = FB_HEIGHT
) (
   input  logic               clk50,
   input  logic               reset_n,
   input  logic [NREQ-1:0]    req_valid,
   output logic [NREQ-1:0]    req_ready,
   input  logic [NREQ*11-1:0] req_x,
   input  logic [NREQ*11-1:0] req_y,
   input  logic [NREQ*24-1:0] req_rgb,
   input  logic               clear_start,
   input  logic [23:0]        clear_color,
   output logic               clear_busy,
   output logic               clear_done,
   output logic [10:0]        fb_x,
   output logic [10:0]        fb_y,
   output logic [7:0]         fb_r,
   output logic [7:0]         fb_g,
   output logic [7:0]         fb_b,
   output logic               fb_pixel_write,
   output logic               fb_pixel_color,
   output logic [15:0]        dropped_count
);

   state_t          state;
   coord_t          cx;
   coord_t          cy;
   rgb_t            fill;
   logic [NREQ-1:0] arb_req;
   logic [NREQ-1:0] grant;
   coord_t          sel_x;
   coord_t          sel_y;
   rgb_t            sel_rgb;
   logic            in_range;

   // A clear request in IDLE wins over clients, so nobody is offered the port that cycle.
   assign arb_req = (reset_n && state == ST_IDLE && !clear_start) ? req_valid : '0;

   rr_arbiter #(.N(NREQ)) u_arb (
      .clk50   (clk50),
      .reset_n (reset_n),
      .req     (arb_req),
      .advance (|grant),
      .grant   (grant)
   );

   assign req_ready      = grant;
   assign fb_pixel_color = 1'b0;

   always_comb begin
      sel_x   = '0;
      sel_y   = '0;
      sel_rgb = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            sel_x   = req_x[i*11 +: 11];
            sel_y   = req_y[i*11 +: 11];
            sel_rgb = req_rgb[i*24 +: 24];
         end
      end
   end

   assign in_range = ({21'd0, sel_x} < 32'(WIDTH)) && ({21'd0, sel_y} < 32'(HEIGHT));

   always_ff @(posedge clk50 or negedge reset_n) begin
      if (!reset_n) begin
         state          <= ST_IDLE;
         cx             <= '0;
         cy             <= '0;
         fill           <= '0;
         fb_x           <= '0;
         fb_y           <= '0;
         fb_r           <= '0;
         fb_g           <= '0;
         fb_b           <= '0;
         fb_pixel_write <= 1'b0;
         clear_busy     <= 1'b0;
         clear_done     <= 1'b0;
         dropped_count  <= '0;
      end else begin
         fb_pixel_write <= 1'b0;
         clear_busy     <= 1'b0;
         clear_done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clear_start) begin
                  fill  <= rgb_t'(clear_color);
                  cx    <= '0;
                  cy    <= '0;
                  state <= ST_CLEAR;
               end else if (|grant) begin
                  if (in_range) begin
                     fb_x           <= sel_x;
                     fb_y           <= sel_y;
                     fb_r           <= sel_rgb.r;
                     fb_g           <= sel_rgb.g;
                     fb_b           <= sel_rgb.b;
                     fb_pixel_write <= 1'b1;
                  end else if (dropped_count != 16'hFFFF) begin
                     dropped_count <= dropped_count + 16'd1;
                  end
               end
            end
            ST_CLEAR: begin
               fb_x           <= cx;
               fb_y           <= cy;
               fb_r           <= fill.r;
               fb_g           <= fill.g;
               fb_b           <= fill.b;
               fb_pixel_write <= 1'b1;
               clear_busy     <= 1'b1;
               if (cx == coord_t'(WIDTH - 1)) begin
                  cx <= '0;
                  if (cy == coord_t'(HEIGHT - 1)) begin
                     cy         <= '0;
                     clear_done <= 1'b1;
                     state      <= ST_IDLE;
                  end else begin
                     cy <= cy + 11'd1;
                  end
               end else begin
                  cx <= cx + 11'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/fb_write_scheduler.md
Name: fb_write_scheduler

Overview:
- Owns the single pixel-write port of the colour VGA framebuffer (x, y, r, g, b, pixel_write).
- Shares that port between NREQ drawing clients using round-robin arbitration with valid/ready handshakes.
- Contains a clear-screen sequencer that fills every pixel with one colour at one pixel per cycle.
- Sits between the drawing engines and the framebuffer, in the clk50 domain.

Parameters:
- NREQ, 2, number of requesting clients (1..8).
- WIDTH, 640, active pixels per line.
- HEIGHT, 480, active lines.

Ports:
- clk50  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  NREQ  per-client write request.
- req_ready  out  NREQ  per-client accept; a transfer occurs when valid and ready are both high.
- req_x  in  NREQ x 11  per-client pixel column.
- req_y  in  NREQ x 11  per-client pixel row.
- req_rgb  in  NREQ x 24  per-client colour, packed {r,g,b}.
- clear_start  in  1  single-cycle request to clear the screen.
- clear_color  in  24  fill colour, sampled with clear_start.
- clear_busy  out  1  clear in progress.
- clear_done  out  1  one-cycle pulse marking the last clear write.
- fb_x  out  11  framebuffer write column.
- fb_y  out  11  framebuffer write row.
- fb_r  out  8  framebuffer write red.
- fb_g  out  8  framebuffer write green.
- fb_b  out  8  framebuffer write blue.
- fb_pixel_write  out  1  framebuffer write strobe.
- fb_pixel_color  out  1  tied to 0.
- dropped_count  out  16  saturating count of out-of-range requests.

Behaviour:
- Reset: asynchronous on reset_n low.
  - All registered outputs go to 0.
  - State returns to IDLE.
  - Arbiter pointer resets so client 0 has top priority.
  - req_ready is forced to 0 while reset_n is low.
  - A reset mid-clear aborts the clear with no clear_done.
- States: IDLE and CLEAR.
- IDLE, arbitration:
  - Round-robin search starts at (last_grant+1) mod NREQ.
  - The first client with req_valid high is granted.
  - req_ready is combinational: one-hot on the granted client, all zero if no client is valid.
  - Ungranted clients hold their request stable. No client is starved; each waits at most NREQ-1 grants.
  - last_grant updates only on a completed transfer.
- Write path, 1-cycle latency:
  - The transfer is accepted at edge N.
  - fb_x, fb_y, fb_r, fb_g, fb_b and fb_pixel_write=1 are presented in cycle N..N+1.
  - fb_pixel_write is 0 in any cycle with no write. Throughput is one write per cycle.
- Out-of-range (req_x >= WIDTH or req_y >= HEIGHT):
  - The request is still accepted (ready high).
  - No write is issued.
  - dropped_count increments and saturates at 16'hFFFF.
- Clear start:
  - clear_start is sampled only in IDLE.
  - It beats any pending request in the same cycle: req_ready is all zero that cycle and no grant is made.
  - clear_color is latched at the same edge.
  - State moves to CLEAR with counters cx=0, cy=0.
- CLEAR:
  - Each cycle registers a write of (cx, cy, latched colour).
  - cx increments 0..WIDTH-1; on wrap cx returns to 0 and cy increments.
  - On (WIDTH-1, HEIGHT-1): the state returns to IDLE and clear_done is asserted for exactly the cycle in which that last write is presented.
  - A clear accepted at edge 0 gives writes in cycles 1..WIDTH*HEIGHT.
  - clear_busy is high exactly in cycles 1..WIDTH*HEIGHT.
  - req_ready is 0 throughout CLEAR.
  - clear_start during CLEAR is ignored.
  - Client requests can be accepted again in cycle WIDTH*HEIGHT; their writes appear in cycle WIDTH*HEIGHT+1.
- Widths:
  - Counters are 11-bit.
  - Comparisons are unsigned against the parameters, zero-extended.

Decomposition:
- fb_pkg holds:
  - typedef coord_t = logic [10:0].
  - typedef rgb_t = struct packed {r, g, b} of 8 bits each.
  - constants FB_WIDTH=640 and FB_HEIGHT=480.
- Sub-module rr_arbiter (parameter N):
  - Inputs: req vector and an advance strobe.
  - Output: one-hot grant.
  - Owns the last_grant pointer and resets so index 0 has top priority.

Test Plan:
- Reset, then client0 requests (5,7,24'hFF0000) → req_ready=2'b01 in the same cycle; the next cycle shows fb_x=5, fb_y=7, fb_r=FF, fb_g=00, fb_b=00, fb_pixel_write=1; the cycle after shows fb_pixel_write=0.
- Both clients hold valid for 4 cycles → grants 0,1,0,1; four consecutive write cycles with alternating coordinates.
- Client1 requests (640,0) and then (0,480) → both accepted, fb_pixel_write stays 0, dropped_count=2.
- WIDTH=4, HEIGHT=3, clear_start with colour 24'h00FF00 while client0 is valid → writes (0,0),(1,0)…(3,2) in cycles 1..12; clear_busy high for 12 cycles; clear_done only in cycle 12; client0 is accepted in cycle 12 and written in cycle 13.
- clear_start pulsed again at cycle 5 of a clear → no restart; total writes are still 12.
- reset_n pulled low at cycle 6 of a clear → outputs are 0 immediately and no clear_done; after release, a new request is granted to client0 first.
